// File: rtl/mem_lsu_misaligned.sv
// Core-wide constants shared by the memory stage.
package core_pkg;

    parameter int unsigned Xlen = 32;

    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_type_e;

endpackage

// mem_lsu_misaligned
// Memory-stage load/store unit. An access that fits in one aligned bus word takes one bus
// transaction. An access that crosses a word boundary is split into two aligned beats, and the
// two read beats are merged into one load result. The pipeline is stalled through mem_busy_o.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   valid_inst_i          instruction in the stage is valid
//   mem_type_i            none / load / store
//   addr_i, wdata_i       byte address and right-aligned store data
//   funct3_i              [1:0] access size (B/H/W/D), [2] zero-extend loads
//   rdata_o               extended load result, valid in the final-response cycle only
//   mem_busy_o            stall request to the pipeline
//   misalign_o            boundary-crossing access rejected (MisalignEn = 0)
//   mem_*                 single-port data-memory request/response interface
module mem_lsu_misaligned
    import core_pkg::*;
#(
    parameter int unsigned Xlen       = core_pkg::Xlen,
    parameter int unsigned MaskBits   = Xlen / 8,
    parameter bit          MisalignEn = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_inst_i,
    input  logic [1:0]          mem_type_i,
    input  logic [Xlen-1:0]     addr_i,
    input  logic [Xlen-1:0]     wdata_i,
    input  logic [2:0]          funct3_i,
    output logic [Xlen-1:0]     rdata_o,
    output logic                mem_busy_o,
    output logic                misalign_o,
    input  logic                mem_ready_i,
    output logic                mem_valid_o,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    localparam int unsigned W    = Xlen / 8;
    localparam int unsigned OffW = $clog2(W);

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StResp0,
        StReq1,
        StResp1
    } state_e;

    state_e state_q, state_d;
    logic   valid_q, valid_d;

    // Registered bus request; beat1 fields wait in their own registers until needed.
    logic [Xlen-1:0]     out_addr_q, out_addr_d;
    logic [Xlen-1:0]     out_wdata_q, out_wdata_d;
    logic [MaskBits-1:0] out_mask_q, out_mask_d;
    logic [Xlen-1:0]     addr1_q, addr1_d;
    logic [Xlen-1:0]     wdata1_q, wdata1_d;
    logic [MaskBits-1:0] mask1_q, mask1_d;
    logic [OffW-1:0]     off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                zext_q, zext_d;
    logic                split_q, split_d;
    logic [Xlen-1:0]     lo_q, lo_d;

    // Request decode
    logic [OffW-1:0]       off;
    logic [3:0]            nbytes;
    logic [7:0]            nmask;
    logic                  split;
    logic                  is_req;
    logic                  is_store;
    logic [Xlen-1:0]       base;
    logic [2*Xlen-1:0]     wdata_wide;
    logic [2*MaskBits-1:0] mask_wide;

    always_comb begin
        off = addr_i[OffW-1:0];
        unique case (funct3_i[1:0])
            2'd0:    begin nbytes = 4'd1; nmask = 8'h01; end
            2'd1:    begin nbytes = 4'd2; nmask = 8'h03; end
            2'd2:    begin nbytes = 4'd4; nmask = 8'h0f; end
            default: begin nbytes = 4'd8; nmask = 8'hff; end
        endcase
        split    = (5'(off) + 5'(nbytes)) > 5'(W);
        is_req   = valid_inst_i && (mem_type_i != MemNone);
        is_store = (mem_type_i == MemStore);
        base     = {addr_i[Xlen-1:OffW], {OffW{1'b0}}};
        // Shifting into a double-width vector yields both beats at once: the low half is
        // beat0 and the high half is what spills over into the next word.
        wdata_wide = {{Xlen{1'b0}}, wdata_i} << {off, 3'b000};
        mask_wide  = is_store ? ((2*MaskBits)'(nmask) << off) : '0;
    end

    // FSM next state and control outputs
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        out_mask_d  = out_mask_q;
        addr1_d     = addr1_q;
        wdata1_d    = wdata1_q;
        mask1_d     = mask1_q;
        off_d       = off_q;
        size_d      = size_q;
        zext_d      = zext_q;
        split_d     = split_q;
        lo_d        = lo_q;
        mem_busy_o  = 1'b0;
        misalign_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_req) begin
                    if (split && !MisalignEn) begin
                        misalign_o = 1'b1;
                    end else begin
                        mem_busy_o  = 1'b1;
                        state_d     = StReq0;
                        valid_d     = 1'b1;
                        out_addr_d  = base;
                        out_wdata_d = wdata_wide[Xlen-1:0];
                        out_mask_d  = mask_wide[MaskBits-1:0];
                        addr1_d     = base + Xlen'(W);
                        wdata1_d    = wdata_wide[2*Xlen-1:Xlen];
                        mask1_d     = mask_wide[2*MaskBits-1:MaskBits];
                        off_d       = off;
                        size_d      = funct3_i[1:0];
                        zext_d      = funct3_i[2];
                        split_d     = split;
                    end
                end
            end
            StReq0: begin
                mem_busy_o = 1'b1;
                if (mem_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StResp0;
                end
            end
            StResp0: begin
                mem_busy_o = 1'b1;
                if (mem_rvalid_i) begin
                    lo_d = mem_rdata_i;
                    if (split_q) begin
                        state_d     = StReq1;
                        valid_d     = 1'b1;
                        out_addr_d  = addr1_q;
                        out_wdata_d = wdata1_q;
                        out_mask_d  = mask1_q;
                    end else begin
                        mem_busy_o = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end
            StReq1: begin
                mem_busy_o = 1'b1;
                if (mem_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StResp1;
                end
            end
            StResp1: begin
                mem_busy_o = 1'b1;
                if (mem_rvalid_i) begin
                    mem_busy_o = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Data path registers carry no reset; they are only observed behind valid control state.
    always_ff @(posedge clk_i) begin
        out_addr_q  <= out_addr_d;
        out_wdata_q <= out_wdata_d;
        out_mask_q  <= out_mask_d;
        addr1_q     <= addr1_d;
        wdata1_q    <= wdata1_d;
        mask1_q     <= mask1_d;
        off_q       <= off_d;
        size_q      <= size_d;
        zext_q      <= zext_d;
        split_q     <= split_d;
        lo_q        <= lo_d;
    end

    assign mem_valid_o = valid_q;
    assign mem_addr_o  = out_addr_q;
    assign mem_wdata_o = out_wdata_q;
    assign mem_wmask_o = out_mask_q;

    // Load merge and extension. In Resp1 lo_q still holds beat0, so the concatenation
    // lines up the two words before the byte offset is shifted out.
    logic [2*Xlen-1:0] merge_wide;
    logic [2*Xlen-1:0] merge_shift;
    logic [Xlen-1:0]   raw;
    logic [3:0]        nbytes_q;
    logic              sign;
    logic [7:0]        fill;

    always_comb begin
        merge_wide  = split_q ? {mem_rdata_i, lo_q} : {{Xlen{1'b0}}, mem_rdata_i};
        merge_shift = merge_wide >> {off_q, 3'b000};
        raw         = merge_shift[Xlen-1:0];
        unique case (size_q)
            2'd0:    begin nbytes_q = 4'd1; sign = raw[7];      end
            2'd1:    begin nbytes_q = 4'd2; sign = raw[15];     end
            2'd2:    begin nbytes_q = 4'd4; sign = raw[31];     end
            default: begin nbytes_q = 4'd8; sign = raw[Xlen-1]; end
        endcase
        fill    = zext_q ? 8'h00 : {8{sign}};
        rdata_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (4'(i) < nbytes_q) begin
                rdata_o[8*i +: 8] = raw[8*i +: 8];
            end else begin
                rdata_o[8*i +: 8] = fill;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu_misaligned.sv
// Directed bench: 32-bit unit with splitting, 32-bit unit rejecting misaligned accesses,
// and a 64-bit unit. Expected values are hand-computed constants.
module tb_mem_lsu_misaligned;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_a, valid_b, valid_c;
    logic [1:0]  mem_type;
    logic [63:0] addr, wdata, mem_rdata;
    logic [2:0]  funct3;
    logic        mem_ready, mem_rvalid;

    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_mask;
    logic        a_busy, a_mis, a_valid;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic [3:0]  b_mask;
    logic        b_busy, b_mis, b_valid;
    logic [63:0] c_rdata, c_addr, c_wdata;
    logic [7:0]  c_mask;
    logic        c_busy, c_mis, c_valid;

    mem_lsu_misaligned #(.Xlen(32), .MisalignEn(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .valid_inst_i(valid_a), .mem_type_i(mem_type),
        .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .funct3_i(funct3), .rdata_o(a_rdata),
        .mem_busy_o(a_busy), .misalign_o(a_mis), .mem_ready_i(mem_ready),
        .mem_valid_o(a_valid), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
        .mem_wmask_o(a_mask), .mem_rdata_i(mem_rdata[31:0]), .mem_rvalid_i(mem_rvalid)
    );

    mem_lsu_misaligned #(.Xlen(32), .MisalignEn(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .valid_inst_i(valid_b), .mem_type_i(mem_type),
        .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .funct3_i(funct3), .rdata_o(b_rdata),
        .mem_busy_o(b_busy), .misalign_o(b_mis), .mem_ready_i(mem_ready),
        .mem_valid_o(b_valid), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
        .mem_wmask_o(b_mask), .mem_rdata_i(mem_rdata[31:0]), .mem_rvalid_i(mem_rvalid)
    );

    mem_lsu_misaligned #(.Xlen(64), .MisalignEn(1'b1)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .valid_inst_i(valid_c), .mem_type_i(mem_type),
        .addr_i(addr), .wdata_i(wdata), .funct3_i(funct3), .rdata_o(c_rdata),
        .mem_busy_o(c_busy), .misalign_o(c_mis), .mem_ready_i(mem_ready),
        .mem_valid_o(c_valid), .mem_addr_o(c_addr), .mem_wdata_o(c_wdata),
        .mem_wmask_o(c_mask), .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid)
    );

    // Observation mux so one access task serves the 32- and 64-bit units.
    logic        sel_wide;
    logic        obs_busy, obs_valid;
    logic [63:0] obs_addr, obs_wdata, obs_rdata;
    logic [7:0]  obs_mask;
    assign obs_busy  = sel_wide ? c_busy  : a_busy;
    assign obs_valid = sel_wide ? c_valid : a_valid;
    assign obs_addr  = sel_wide ? c_addr  : {32'h0, a_addr};
    assign obs_wdata = sel_wide ? c_wdata : {32'h0, a_wdata};
    assign obs_rdata = sel_wide ? c_rdata : {32'h0, a_rdata};
    assign obs_mask  = sel_wide ? c_mask  : {4'h0, a_mask};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [63:0] ea, input logic [63:0] ew,
                              input logic [7:0] em);
        check_eq({tag, " valid"}, 64'(obs_valid), 64'd1);
        check_eq({tag, " addr"}, obs_addr, ea);
        check_eq({tag, " wdata"}, obs_wdata, ew);
        check_eq({tag, " wmask"}, 64'(obs_mask), 64'(em));
    endtask

    task automatic idle_inputs();
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        valid_c    = 1'b0;
        mem_type   = MemNone;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Drives one access through a zero-wait bus (except stall1 cycles of ready low in Req1)
    // and checks every cycle against the expected beat fields and timing.
    task automatic run_access(input string tag, input bit wide, input logic [1:0] mt,
                              input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd0, input logic [63:0] rd1, input bit split,
                              input int stall1,
                              input logic [63:0] ea0, input logic [63:0] ew0,
                              input logic [7:0] em0,
                              input logic [63:0] ea1, input logic [63:0] ew1,
                              input logic [7:0] em1, input logic [63:0] erd);
        sel_wide = wide;
        @(posedge clk); #1;
        if (wide) valid_c = 1'b1;
        else valid_a = 1'b1;
        mem_type = mt; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check_eq({tag, " accept busy"}, 64'(obs_busy), 64'd1);
        check_eq({tag, " accept valid"}, 64'(obs_valid), 64'd0);

        @(posedge clk); #1;
        valid_a = 1'b0; valid_c = 1'b0; mem_type = MemNone; mem_ready = 1'b1;
        @(negedge clk);
        check_beat({tag, " b0"}, ea0, ew0, em0);

        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd0;
        @(negedge clk);
        if (!split) begin
            check_eq({tag, " done busy"}, 64'(obs_busy), 64'd0);
            if (mt == MemLoad) check_eq({tag, " rdata"}, obs_rdata, erd);
        end else begin
            check_eq({tag, " resp0 busy"}, 64'(obs_busy), 64'd1);
            check_eq({tag, " resp0 valid"}, 64'(obs_valid), 64'd0);

            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_ready = (stall1 == 0);
            @(negedge clk);
            check_beat({tag, " b1"}, ea1, ew1, em1);
            for (int k = 0; k < stall1; k++) begin
                @(posedge clk); #1;
                mem_ready = (k == stall1 - 1);
                @(negedge clk);
                check_beat({tag, " b1 stall"}, ea1, ew1, em1);
                check_eq({tag, " b1 stall busy"}, 64'(obs_busy), 64'd1);
            end

            @(posedge clk); #1;
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd1;
            @(negedge clk);
            check_eq({tag, " done busy"}, 64'(obs_busy), 64'd0);
            check_eq({tag, " resp1 valid"}, 64'(obs_valid), 64'd0);
            if (mt == MemLoad) check_eq({tag, " rdata"}, obs_rdata, erd);
        end

        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_eq({tag, " idle busy"}, 64'(obs_busy), 64'd0);
        check_eq({tag, " idle valid"}, 64'(obs_valid), 64'd0);
    endtask

    initial begin
        idle_inputs();
        sel_wide  = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        funct3    = 3'b010;
        rst       = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("reset a_valid", 64'(a_valid), 64'd0);
        check_eq("reset a_busy", 64'(a_busy), 64'd0);
        check_eq("reset b_mis", 64'(b_mis), 64'd0);
        check_eq("reset c_valid", 64'(c_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          tag          wide type      f3      addr     wdata
        //          rd0                    rd1                    split stall
        //          beat0 addr/wdata/mask        beat1 addr/wdata/mask          rdata
        run_access("lw_aligned", 0, MemLoad, 3'b010, 64'h100, 64'h0,
                   64'hDEADBEEF, 64'h0, 0, 0,
                   64'h100, 64'h0, 8'h00, 64'h0, 64'h0, 8'h00, 64'hDEADBEEF);

        // Reset while waiting for the beat0 response.
        @(posedge clk); #1;
        valid_a = 1'b1; mem_type = MemLoad; funct3 = 3'b010; addr = 64'h200;
        @(posedge clk); #1;
        valid_a = 1'b0; mem_type = MemNone; mem_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_mid req valid", 64'(a_valid), 64'd1);
        @(posedge clk); #1;
        mem_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid valid", 64'(a_valid), 64'd0);
        check_eq("rst_mid busy", 64'(a_busy), 64'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 64'h12345678;
        @(negedge clk);
        check_eq("rst_mid late rvalid busy", 64'(a_busy), 64'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid late rvalid valid", 64'(a_valid), 64'd0);

        run_access("sw_split", 0, MemStore, 3'b010, 64'h103, 64'h11223344,
                   64'h0, 64'h0, 1, 0,
                   64'h100, 64'h44000000, 8'h08, 64'h104, 64'h00112233, 8'h07, 64'h0);
        run_access("lh_split", 0, MemLoad, 3'b001, 64'h103, 64'h0,
                   64'h80AABBCC, 64'h000000FF, 1, 0,
                   64'h100, 64'h0, 8'h00, 64'h104, 64'h0, 8'h00, 64'hFFFFFF80);
        run_access("lhu_split", 0, MemLoad, 3'b101, 64'h103, 64'h0,
                   64'h80AABBCC, 64'h000000FF, 1, 0,
                   64'h100, 64'h0, 8'h00, 64'h104, 64'h0, 8'h00, 64'h0000FF80);
        run_access("lh_inword", 0, MemLoad, 3'b001, 64'h101, 64'h0,
                   64'h12345678, 64'h0, 0, 0,
                   64'h100, 64'h0, 8'h00, 64'h0, 64'h0, 8'h00, 64'h00003456);
        run_access("lb_sign", 0, MemLoad, 3'b000, 64'h102, 64'h0,
                   64'h00800000, 64'h0, 0, 0,
                   64'h100, 64'h0, 8'h00, 64'h0, 64'h0, 8'h00, 64'hFFFFFF80);
        run_access("sw_wrap", 0, MemStore, 3'b010, 64'hFFFFFFFE, 64'hAABBCCDD,
                   64'h0, 64'h0, 1, 0,
                   64'hFFFFFFFC, 64'hCCDD0000, 8'h0C, 64'h0, 64'h0000AABB, 8'h03, 64'h0);
        run_access("lw_stall", 0, MemLoad, 3'b010, 64'h102, 64'h0,
                   64'h44332211, 64'h88776655, 1, 3,
                   64'h100, 64'h0, 8'h00, 64'h104, 64'h0, 8'h00, 64'h66554433);

        // Misaligned store rejected by the non-splitting unit.
        @(posedge clk); #1;
        valid_b = 1'b1; mem_type = MemStore; funct3 = 3'b010; addr = 64'h102;
        wdata = 64'h55;
        @(negedge clk);
        check_eq("nomis misalign", 64'(b_mis), 64'd1);
        check_eq("nomis busy", 64'(b_busy), 64'd0);
        @(posedge clk); #1;
        valid_b = 1'b0; mem_type = MemNone;
        @(negedge clk);
        check_eq("nomis misalign drop", 64'(b_mis), 64'd0);
        check_eq("nomis valid", 64'(b_valid), 64'd0);
        // An aligned load still goes through on the same unit.
        @(posedge clk); #1;
        valid_b = 1'b1; mem_type = MemLoad; funct3 = 3'b010; addr = 64'h104;
        @(negedge clk);
        check_eq("nomis aligned misalign", 64'(b_mis), 64'd0);
        check_eq("nomis aligned busy", 64'(b_busy), 64'd1);
        @(posedge clk); #1;
        valid_b = 1'b0; mem_type = MemNone; mem_ready = 1'b1;
        @(negedge clk);
        check_eq("nomis aligned valid", 64'(b_valid), 64'd1);
        check_eq("nomis aligned addr", 64'(b_addr), 64'h104);
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hCAFEF00D;
        @(negedge clk);
        check_eq("nomis aligned done busy", 64'(b_busy), 64'd0);
        check_eq("nomis aligned rdata", 64'(b_rdata), 64'hCAFEF00D);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        run_access("sd_split64", 1, MemStore, 3'b011, 64'h1005, 64'h0102030405060708,
                   64'h0, 64'h0, 1, 0,
                   64'h1000, 64'h0607080000000000, 8'hE0,
                   64'h1008, 64'h0000000102030405, 8'h1F, 64'h0);
        run_access("ld_split64", 1, MemLoad, 3'b011, 64'h1005, 64'h0,
                   64'h8877665544332211, 64'h00000000FFEEDDCC, 1, 0,
                   64'h1000, 64'h0, 8'h00, 64'h1008, 64'h0, 8'h00, 64'h00FFEEDDCC887766);
        run_access("lw_split64", 1, MemLoad, 3'b010, 64'h1006, 64'h0,
                   64'h8877665544332211, 64'h00000000FFEEDDCC, 1, 0,
                   64'h1000, 64'h0, 8'h00, 64'h1008, 64'h0, 8'h00, 64'hFFFFFFFFDDCC8877);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
